wb_uart_slave: RTL and testbench



---
 rtl/wb_uart_slave.sv | 236 +++++++++++++++++++++++
 tb/tb_wb_uart_slave.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_slave.sv
// Wishbone classic slave UART: 8N1 transmitter behind a TX FIFO, single-byte RX
// holding register, programmable baud divisor and a registered level interrupt.
module wb_uart_slave #(
    parameter int          TX_DEPTH    = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        wb_clk_i,
    input  logic        resetn,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    output logic        wbs_ack_o,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    localparam int AW = $clog2(TX_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    logic [1:0]  reg_sel;
    logic        access, wr, rd;
    logic [31:0] rdata;
    logic [15:0] div;
    logic [1:0]  irq_en;

    logic [7:0]  fifo_mem [TX_DEPTH];
    logic [AW:0] wptr, rptr;
    logic        tx_full, tx_empty, push;

    uart_state_t tx_state, tx_next;
    logic [15:0] tx_cnt, tx_div_q;
    logic [2:0]  tx_idx;
    logic [7:0]  tx_shift;
    logic        tx_bit_end, tx_load, tx_busy;

    uart_state_t rx_state, rx_next;
    logic        rx_s1, rx_s2, rx_prev, rx_fall;
    logic [15:0] rx_cnt, rx_div_q;
    logic [2:0]  rx_idx;
    logic [7:0]  rx_shift, rx_byte;
    logic        rx_tick, rx_stop_end, rx_valid, overrun, frame_err, rd_data;

    wire unused_bits = &{1'b0, wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

    assign reg_sel = wbs_adr_i[3:2];
    assign access  = wbs_ack_o & wbs_stb_i & wbs_cyc_i;
    assign wr      = access & wbs_we_i;
    assign rd      = access & ~wbs_we_i;
    assign rd_data = rd && (reg_sel == 2'd0);

    always_ff @(posedge wb_clk_i or negedge resetn) begin
        if (!resetn) wbs_ack_o <= 1'b0;
        else         wbs_ack_o <= wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    end

    always_comb begin
        rdata = 32'd0;
        case (reg_sel)
            2'd0: rdata = {24'd0, rx_byte};
            2'd1: rdata = {26'd0, frame_err, tx_busy, tx_empty, tx_full, overrun, rx_valid};
            2'd2: rdata = {16'd0, div};
            2'd3: rdata = {30'd0, irq_en};
            default: rdata = 32'd0;
        endcase
    end

    assign wbs_dat_o = rd ? rdata : 32'd0;

    always_ff @(posedge wb_clk_i or negedge resetn) begin
        if (!resetn) begin
            div    <= DEFAULT_DIV;
            irq_en <= 2'b00;
            irq    <= 1'b0;
        end else begin
            if (wr && reg_sel == 2'd2 && wbs_sel_i[1:0] == 2'b11) div <= wbs_dat_i[15:0];
            if (wr && reg_sel == 2'd3 && wbs_sel_i[0]) irq_en <= wbs_dat_i[1:0];
            irq <= (irq_en[0] & rx_valid) | (irq_en[1] & tx_empty & ~tx_busy);
        end
    end

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign tx_empty = (wptr == rptr);
    assign tx_full  = ((wptr - rptr) == (AW+1)'(TX_DEPTH));
    assign push     = wr && reg_sel == 2'd0 && wbs_sel_i[0] && (!tx_full || tx_load);

    always_ff @(posedge wb_clk_i) begin
        if (push) fifo_mem[wptr[AW-1:0]] <= wbs_dat_i[7:0];
    end

    always_ff @(posedge wb_clk_i or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push)    wptr <= wptr + {{AW{1'b0}}, 1'b1};
            if (tx_load) rptr <= rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    assign tx_bit_end = (tx_cnt == tx_div_q);

    always_ff @(posedge wb_clk_i or negedge resetn) begin
        if (!resetn) tx_state <= IDLE;
        else         tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            IDLE:  if (!tx_empty) tx_next = START;
            START: if (tx_bit_end) tx_next = DATA;
            DATA:  if (tx_bit_end && tx_idx == 3'd7) tx_next = STOP;
            STOP:  if (tx_bit_end) tx_next = tx_empty ? IDLE : START;
            default: tx_next = IDLE;
        endcase
    end

    always_comb begin
        tx_load = (tx_next == START) && (tx_state != START);
        tx_busy = (tx_state != IDLE);
        uart_tx = 1'b1;
        case (tx_state)
            START:   uart_tx = 1'b0;
            DATA:    uart_tx = tx_shift[0];
            default: uart_tx = 1'b1;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge resetn) begin
        if (!resetn) begin
            tx_cnt   <= 16'd0;
            tx_div_q <= 16'd0;
            tx_idx   <= 3'd0;
            tx_shift <= 8'd0;
        end else if (tx_load) begin
            tx_cnt   <= 16'd0;
            tx_div_q <= div;
            tx_idx   <= 3'd0;
            tx_shift <= fifo_mem[rptr[AW-1:0]];
        end else if (tx_state != IDLE) begin
            if (tx_bit_end) begin
                tx_cnt <= 16'd0;
                if (tx_state == DATA) begin
                    tx_shift <= {1'b1, tx_shift[7:1]};
                    tx_idx   <= tx_idx + 3'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge resetn) begin
        if (!resetn) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev & ~rx_s2;
    assign rx_tick = (rx_state == START) ? (rx_cnt == (rx_div_q >> 1)) : (rx_cnt == rx_div_q);

    always_ff @(posedge wb_clk_i or negedge resetn) begin
        if (!resetn) rx_state <= IDLE;
        else         rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:  if (rx_fall) rx_next = START;
            START: if (rx_tick) rx_next = rx_s2 ? IDLE : DATA;
            DATA:  if (rx_tick && rx_idx == 3'd7) rx_next = STOP;
            STOP:  if (rx_tick) rx_next = IDLE;
            default: rx_next = IDLE;
        endcase
    end

    always_comb begin
        rx_stop_end = (rx_state == STOP) && rx_tick;
    end

    always_ff @(posedge wb_clk_i or negedge resetn) begin
        if (!resetn) begin
            rx_cnt   <= 16'd0;
            rx_div_q <= 16'd0;
            rx_idx   <= 3'd0;
            rx_shift <= 8'd0;
        end else if (rx_state == IDLE) begin
            rx_cnt <= 16'd0;
            rx_idx <= 3'd0;
            if (rx_fall) rx_div_q <= div;
        end else if (rx_tick) begin
            rx_cnt <= 16'd0;
            if (rx_state == DATA) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_idx   <= rx_idx + 3'd1;
            end
        end else begin
            rx_cnt <= rx_cnt + 16'd1;
        end
    end

    // A DATA read landing with a good stop bit hands over the new byte without an overrun.
    always_ff @(posedge wb_clk_i or negedge resetn) begin
        if (!resetn) begin
            rx_byte   <= 8'd0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (wr && reg_sel == 2'd1 && wbs_sel_i[0]) begin
                if (wbs_dat_i[1]) overrun   <= 1'b0;
                if (wbs_dat_i[5]) frame_err <= 1'b0;
            end
            if (rx_stop_end && rx_s2 && (!rx_valid || rd_data)) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rd_data) begin
                rx_valid <= 1'b0;
            end
            if (rx_stop_end && !rx_s2) frame_err <= 1'b1;
            if (rx_stop_end && rx_s2 && rx_valid && !rd_data) overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_uart_slave.sv
// Directed bench for wb_uart_slave: bus handshake, TX framing and FIFO, RX with
// error/overrun flags, interrupt and asynchronous reset behaviour.
module tb_wb_uart_slave;
    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] adr, dat_i, dat_o;
    logic        we, stb, cyc, ack;
    logic [3:0]  sel;
    logic        rx, tx, irq_line;

    int checks = 0;
    int errors = 0;
    int lastLat;
    logic lastAckAfter;

    wb_uart_slave #(.TX_DEPTH(8), .DEFAULT_DIV(16'd433)) dut (
        .wb_clk_i (clk),
        .resetn   (resetn),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat_i),
        .wbs_dat_o(dat_o),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_ack_o(ack),
        .uart_rx  (rx),
        .uart_tx  (tx),
        .irq      (irq_line)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [1:0] idx, input logic [31:0] wdata,
                                 input logic [3:0] bsel, output logic [31:0] rdata);
        @(negedge clk);
        adr = {28'd0, idx, 2'b00};
        dat_i = wdata;
        we = wr;
        sel = bsel;
        stb = 1'b1;
        cyc = 1'b1;
        lastLat = 0;
        do begin
            @(negedge clk);
            lastLat++;
        end while (!ack && lastLat < 20);
        if (!ack) checkOutput("ack_timeout", 32'(ack), 32'd1);
        rdata = dat_o;
        @(posedge clk);
        #1;
        stb = 1'b0;
        cyc = 1'b0;
        we = 1'b0;
        lastAckAfter = ack;
    endtask

    task automatic wbWrite(input logic [1:0] idx, input logic [31:0] wdata);
        logic [31:0] unusedData;
        applyStimulus(1'b1, idx, wdata, 4'hF, unusedData);
    endtask

    task automatic readCheck(input string tag, input logic [1:0] idx, input logic [31:0] expected);
        logic [31:0] d;
        applyStimulus(1'b0, idx, 32'd0, 4'hF, d);
        checkOutput(tag, d, expected);
    endtask

    task automatic waitTxStart();
        int n = 0;
        while (tx !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) checkOutput("tx_start_timeout", 32'(tx), 32'd0);
    endtask

    // Entered on the negedge showing the first clock of the start bit.
    task automatic checkFrame(input string tag, input logic [7:0] data, input int div);
        logic [9:0] frame;
        int bad = 0;
        frame = {1'b1, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c <= div; c++) begin
                if (tx !== frame[b]) bad++;
                @(negedge clk);
            end
        end
        checkOutput(tag, 32'(bad), 32'd0);
    endtask

    task automatic sendSerial(input logic [7:0] data, input logic stopBit, input int bitClocks);
        logic [9:0] frame;
        frame = {stopBit, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            @(negedge clk);
            rx = frame[b];
            repeat (bitClocks - 1) @(negedge clk);
        end
        @(negedge clk);
        rx = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        resetn = 1'b0;
        adr = '0; dat_i = '0; we = 1'b0; sel = 4'h0; stb = 1'b0; cyc = 1'b0; rx = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("rst_tx", 32'(tx), 32'd1);
        checkOutput("rst_ack", 32'(ack), 32'd0);
        checkOutput("rst_irq", 32'(irq_line), 32'd0);
        checkOutput("rst_dat_o", dat_o, 32'd0);
        readCheck("rst_status", 2'd1, 32'h08);
        readCheck("rst_div", 2'd2, 32'd433);

        wbWrite(2'd2, 32'd3);
        applyStimulus(1'b1, 2'd2, 32'd5, 4'b0001, d);
        readCheck("div_sel_guard", 2'd2, 32'd3);

        fork
            begin
                wbWrite(2'd0, 32'hA5);
                checkOutput("tx_ack_latency", 32'(lastLat), 32'd1);
                checkOutput("tx_ack_one_cycle", 32'(lastAckAfter), 32'd0);
                readCheck("tx_busy_status", 2'd1, 32'h18);
            end
            begin
                waitTxStart();
                checkFrame("tx_frame_a5", 8'hA5, 3);
            end
        join
        repeat (2) @(negedge clk);
        readCheck("tx_idle_status", 2'd1, 32'h08);

        fork
            begin
                for (int i = 0; i < 9; i++) wbWrite(2'd0, 32'(i));
                readCheck("fifo_full_status", 2'd1, 32'h14);
                wbWrite(2'd0, 32'h09);
                checkOutput("fifo_drop_acked", 32'(lastLat), 32'd1);
                readCheck("fifo_full_after_drop", 2'd1, 32'h14);
            end
            begin
                waitTxStart();
                for (int i = 0; i < 9; i++) checkFrame($sformatf("fifo_frame%0d", i), 8'(i), 3);
                checkOutput("fifo_no_tenth_byte", 32'(tx), 32'd1);
            end
        join
        readCheck("fifo_drained", 2'd1, 32'h08);

        wbWrite(2'd2, 32'd7);
        sendSerial(8'h3C, 1'b1, 8);
        repeat (4) @(negedge clk);
        readCheck("rx_status_valid", 2'd1, 32'h09);
        readCheck("rx_data", 2'd0, 32'h3C);
        readCheck("rx_status_cleared", 2'd1, 32'h08);
        sendSerial(8'h3C, 1'b1, 8);
        sendSerial(8'h5A, 1'b1, 8);
        repeat (4) @(negedge clk);
        readCheck("rx_overrun_status", 2'd1, 32'h0B);
        readCheck("rx_data_kept", 2'd0, 32'h3C);
        wbWrite(2'd1, 32'h02);
        readCheck("rx_overrun_clear", 2'd1, 32'h08);

        @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        readCheck("rx_glitch_ignored", 2'd1, 32'h08);
        sendSerial(8'h55, 1'b0, 8);
        repeat (4) @(negedge clk);
        readCheck("rx_frame_err", 2'd1, 32'h28);
        readCheck("rx_frame_discard", 2'd0, 32'h3C);
        wbWrite(2'd1, 32'h20);
        readCheck("rx_frame_err_clear", 2'd1, 32'h08);

        wbWrite(2'd3, 32'h1);
        repeat (2) @(negedge clk);
        checkOutput("irq_quiet", 32'(irq_line), 32'd0);
        sendSerial(8'h11, 1'b1, 8);
        repeat (4) @(negedge clk);
        checkOutput("irq_rx_valid", 32'(irq_line), 32'd1);
        applyStimulus(1'b0, 2'd0, 32'd0, 4'hF, d);
        checkOutput("irq_rx_data", d, 32'h11);
        checkOutput("irq_lag_after_read", 32'(irq_line), 32'd1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("irq_dropped", 32'(irq_line), 32'd0);
        wbWrite(2'd3, 32'h2);
        repeat (2) @(negedge clk);
        checkOutput("irq_tx_idle", 32'(irq_line), 32'd1);
        wbWrite(2'd3, 32'h0);

        wbWrite(2'd2, 32'd3);
        wbWrite(2'd0, 32'h00);
        wbWrite(2'd0, 32'h00);
        wbWrite(2'd0, 32'h00);
        repeat (10) @(negedge clk);
        checkOutput("mid_frame_low", 32'(tx), 32'd0);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("reset_tx_async", 32'(tx), 32'd1);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("reset_tx_idle", 32'(tx), 32'd1);
        readCheck("reset_fifo_empty", 2'd1, 32'h08);
        readCheck("reset_div", 2'd2, 32'd433);
        repeat (60) @(negedge clk);
        checkOutput("reset_no_frame", 32'(tx), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
